// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES core among NREQ requesters; sequences start/done and records job latency.
// Optional watchdog abort enabled by defining AES_ARB_TIMEOUT_EN.
module aes_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int CW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         ack_o,
  output logic [NREQ-1:0]         err_o,
  output logic                    aes_start_o,
  input  logic                    aes_done_i,
  output logic                    busy_o,
  output logic [CW-1:0]           last_cycles_o,
  output logic [$clog2(NREQ)-1:0] last_owner_o
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ACK,
    S_DRAIN,
    S_ABORT
  } state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  owner;
  logic           done_r;
  logic [CW-1:0]  cnt;

  logic           done_rise;
  logic           pick_vld;
  logic [PW-1:0]  pick_idx;
  logic [PW-1:0]  pick_nxt;
  logic [PW-1:0]  scan_idx;
  int             scan_j;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign done_rise = aes_done_i & ~done_r;
  assign busy_o    = (state != S_IDLE);

  // Scan downward in offset so the nearest set bit at or after ptr is the one that survives.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_j   = 0;
    scan_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_j = int'(ptr) + i;
      if (scan_j >= NREQ) scan_j = scan_j - NREQ;
      scan_idx = scan_j[PW-1:0];
      if (req_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign pick_nxt = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

`ifndef AES_ARB_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^(32'(TIMEOUT));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      ptr           <= '0;
      owner         <= '0;
      done_r        <= 1'b0;
      cnt           <= '0;
      gnt_o         <= '0;
      ack_o         <= '0;
      err_o         <= '0;
      aes_start_o   <= 1'b0;
      last_cycles_o <= '0;
      last_owner_o  <= '0;
    end else begin
      done_r <= aes_done_i;
      ack_o  <= '0;
      err_o  <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            owner        <= pick_idx;
            last_owner_o <= pick_idx;
            ptr          <= pick_nxt;
            cnt          <= '0;
            gnt_o        <= NREQ'(1) << pick_idx;
            aes_start_o  <= 1'b1;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= sat_inc(cnt);
          if (done_rise) begin
            state         <= S_ACK;
            ack_o         <= NREQ'(1) << owner;
            aes_start_o   <= 1'b0;
            last_cycles_o <= sat_inc(cnt);
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state         <= S_ABORT;
            err_o         <= NREQ'(1) << owner;
            aes_start_o   <= 1'b0;
            last_cycles_o <= CW'(TIMEOUT);
          end
`endif
        end
        // Grant stays up until the core has dropped done, so the next owner starts on a quiet core.
        S_ACK, S_ABORT: begin
          if (aes_done_i) begin
            state <= S_DRAIN;
          end else begin
            state <= S_IDLE;
            gnt_o <= '0;
          end
        end
        S_DRAIN: begin
          if (!aes_done_i) begin
            state <= S_IDLE;
            gnt_o <= '0;
          end
        end
        default: begin
          state       <= S_IDLE;
          gnt_o       <= '0;
          aes_start_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Scoreboard bench for aes_job_arbiter: completions are predicted when done is driven and checked when ack/err fire.
module tb_aes_job_arbiter;

  localparam int NREQ    = 4;
  localparam int CW      = 32;
  localparam int TIMEOUT = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [NREQ-1:0] req_i = '0;
  logic            aes_done_i = 1'b0;
  logic [NREQ-1:0] gnt_o;
  logic [NREQ-1:0] ack_o;
  logic [NREQ-1:0] err_o;
  logic            aes_start_o;
  logic            busy_o;
  logic [CW-1:0]   last_cycles_o;
  logic [1:0]      last_owner_o;

  aes_job_arbiter #(.NREQ(NREQ), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .ack_o         (ack_o),
    .err_o         (err_o),
    .aes_start_o   (aes_start_o),
    .aes_done_i    (aes_done_i),
    .busy_o        (busy_o),
    .last_cycles_o (last_cycles_o),
    .last_owner_o  (last_owner_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] cycles;
    logic [1:0]  owner;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mptr = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return 2'((p + i) % 4);
    return 2'd0;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("gnt_onehot", 64'($onehot0(gnt_o)), 64'd1);
      if ((ack_o | err_o) != 4'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {56'd0, ack_o, err_o}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_vec", ack_o, mon_e.ack);
          chk("err_vec", err_o, mon_e.err);
          chk("last_cycles", last_cycles_o, mon_e.cycles);
          chk("last_owner", last_owner_o, mon_e.owner);
          chk("done_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1; req_i = '0; aes_done_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mptr = 0;
  endtask

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk_i);
      if (gnt_o != 4'b0) got = 1'b1;
    end
    if (!got) chk("gnt_wait", 64'd0, 64'd1);
  endtask

  task automatic do_job(input int lat, input int hold, input int drop, output int gcyc, output int icyc);
    int k;
    bit got;
    logic [1:0] own;
    exp_t e;
    gcyc = 0;
    icyc = 0;
    wait_gnt(got);
    if (!got) return;
    gcyc = cyc;
    own  = rr_pick(req_i, mptr);
    mptr = (int'(own) + 1) % 4;
    chk("gnt_owner", gnt_o, 4'(1) << own);
    chk("start_hi", aes_start_o, 1);
    for (int i = 1; i < lat; i++) begin
      @(posedge clk_i); #1;
      if (i + 1 == drop) req_i = '0;
    end
    aes_done_i = 1'b1;
    k = cyc;
    e.ack = 4'(1) << own; e.err = 4'b0; e.cycles = 32'(lat); e.owner = own; e.at = k + 1;
    sb.push_back(e);
    repeat (hold) @(posedge clk_i);
    #1 aes_done_i = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk_i);
      if (!busy_o) got = 1'b1;
    end
    if (!got) begin
      chk("idle_wait", 64'd0, 64'd1);
      return;
    end
    icyc = cyc;
    chk("drain_len", 64'(icyc - k), 64'(hold > 1 ? hold + 1 : 2));
  endtask

  initial begin
    int g, ic, prev_ic, t0, c1;
    bit got;
    logic [1:0] own;
    exp_t e;

    // reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_start", aes_start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cycles", last_cycles_o, 0);
    chk("rst_owner", last_owner_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // single job, latency 12
    @(posedge clk_i); #1;
    req_i = 4'b0001;
    t0 = cyc;
    do_job(12, 1, 0, g, ic);
    req_i = '0;
    chk("gnt_latency", 64'(g - t0), 64'd1);

    // all requesters held: round-robin order with back-to-back turnaround
    do_reset();
    req_i = 4'b1111;
    prev_ic = 0;
    for (int j = 0; j < 5; j++) begin
      do_job(3 + j, 1, 0, g, ic);
      if (j > 0) chk("turnaround", 64'(g - prev_ic), 64'd1);
      prev_ic = ic;
    end
    req_i = '0;

    // request withdrawn mid-job still completes
    @(posedge clk_i); #1;
    req_i = 4'b0100;
    do_job(8, 1, 3, g, ic);
    req_i = '0;
    chk("dropped_owner", last_owner_o, 2);

    // done held after rise: drain before the next grant
    @(posedge clk_i); #1;
    req_i = 4'b0011;
    do_job(5, 5, 0, g, ic);
    prev_ic = ic;
    do_job(4, 1, 0, g, ic);
    req_i = '0;
    chk("post_drain_gnt", 64'(g - prev_ic), 64'd1);

    // reset during RUN cycle 4
    @(posedge clk_i); #1;
    req_i = 4'b0001;
    wait_gnt(got);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_i = '0;
    mptr = 0;
    @(negedge clk_i);
    chk("mid_rst_gnt", gnt_o, 0);
    chk("mid_rst_start", aes_start_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_cycles", last_cycles_o, 0);
    chk("mid_rst_owner", last_owner_o, 0);
    repeat (5) @(negedge clk_i);
    chk("mid_rst_quiet", {ack_o, err_o}, 0);

    // no done from the core
    @(posedge clk_i); #1;
    req_i = 4'b1000;
    wait_gnt(got);
    c1 = cyc;
    own = rr_pick(req_i, mptr);
    mptr = (int'(own) + 1) % 4;
    req_i = '0;
    chk("stall_owner", gnt_o, 4'(1) << own);
`ifdef AES_ARB_TIMEOUT_EN
    e.ack = 4'b0; e.err = 4'(1) << own; e.cycles = 32'(TIMEOUT); e.owner = own; e.at = c1 + TIMEOUT;
    sb.push_back(e);
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk_i);
      if (!busy_o) got = 1'b1;
    end
    chk("abort_idle", got, 1);
`else
    e.at = c1;
    repeat (40) @(negedge clk_i);
    chk("stall_busy", busy_o, 1);
    chk("stall_start", aes_start_o, 1);
    chk("stall_gnt", gnt_o, 4'(1) << own);
    chk("stall_err", err_o, 0);
    do_reset();
`endif

    repeat (3) @(negedge clk_i);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
